multi_axis_tracker: RTL and testbench

Parametrised N-axis tracker motor controller, successor to the two-axis photoresistor/manual controller. It sequences axes round-robin and drives one axis at a time through active-low pos/neg motor pairs. Each axis is driven until its error is inside a deadband, or until a per-axis timeout latches a fault. It adds:
- signed, overflow-free error arithmetic;
- shortest-path drive on circular axes;
- a brake dead-time before any reversal or axis switch.

---
 rtl/tracker_pkg.sv | 35 +++
 rtl/tracker_err_calc.sv | 50 +++++
 rtl/multi_axis_tracker.sv | 211 +++++++++++++++++++++
 tb/tb_multi_axis_tracker.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tracker_pkg.sv
// tracker_pkg: shared FSM states, motor line codes and drive direction for
// multi_axis_tracker. Optional feature macro of this slice: TRACKER_HYST_EN.
package tracker_pkg;

    // Tracker sequencer states; exported on the dbg_state port.
    typedef enum logic [1:0] {
        ST_EVAL  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_BRAKE = 2'd2,
        ST_NEXT  = 2'd3
    } state_e;

    // Where the sequencer goes once the dead-time has elapsed.
    typedef enum logic [1:0] {
        RET_NEXT    = 2'd0,  // move on to the following axis
        RET_EVAL    = 2'd1,  // re-evaluate the same axis (reversal)
        RET_RESTART = 2'd2   // mode change: restart from axis 0
    } brake_ret_e;

    // Motor line pair {pos, neg}, both active low.
    localparam logic [1:0] MOT_STOP = 2'b11;
    localparam logic [1:0] MOT_POS  = 2'b01;  // pos line low
    localparam logic [1:0] MOT_NEG  = 2'b10;  // neg line low

    // DIR_UP: effective error positive, drives the neg line low.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic logic [1:0] dir_to_mot(dir_e dir);
        return (dir == DIR_UP) ? MOT_NEG : MOT_POS;
    endfunction

endpackage

// File: rtl/tracker_err_calc.sv
// tracker_err_calc: combinational error evaluation for the selected axis.
// Produces the alignment/start flags and the drive direction, with the
// shortest-path inversion for circular axes in manual mode.
// Macro TRACKER_HYST_EN: start threshold becomes 2*DEADBAND (hysteresis).
module tracker_err_calc
    import tracker_pkg::*;
#(
    parameter int W         = 16,
    parameter int DEADBAND  = 5,
    parameter int HALF_TURN = 180
) (
    input  logic         manual,
    input  logic [W-1:0] sense_a,
    input  logic [W-1:0] sense_b,
    input  logic [W-1:0] target,
    input  logic [W-1:0] actual,
    input  logic         wrap_en,
    output logic         aligned,
    output logic         start,
    output dir_e         dir
);

    localparam logic [W+1:0] DB_L   = (W+2)'(DEADBAND);
    localparam logic [W+1:0] HALF_L = (W+2)'(HALF_TURN);
`ifdef TRACKER_HYST_EN
    localparam logic [W+1:0] START_L = (W+2)'(2 * DEADBAND);
`else
    localparam logic [W+1:0] START_L = DB_L;
`endif

    logic signed [W+1:0] err;
    logic        [W+1:0] abs_err;
    logic                invert;

    // Two extra bits make the subtraction and its negation overflow-free.
    always_comb begin
        if (manual) begin
            err = $signed({2'b00, target}) - $signed({2'b00, actual});
        end else begin
            err = $signed({2'b00, sense_b}) - $signed({2'b00, sense_a});
        end
        abs_err = err[W+1] ? $unsigned(-err) : $unsigned(err);
        aligned = (abs_err <= DB_L);
        start   = (abs_err > START_L);
        invert  = manual && wrap_en && (abs_err > HALF_L);
        // err == 0 is always aligned, so the sign bit alone picks the side.
        dir     = ((!err[W+1]) ^ invert) ? DIR_UP : DIR_DOWN;
    end

endmodule

// File: rtl/multi_axis_tracker.sv
// multi_axis_tracker: round-robin N-axis motor controller. One axis at a time
// is driven through its active-low pos/neg pair until aligned or timed out;
// every stop, reversal or axis switch passes through a braking dead-time.
// Macro TRACKER_HYST_EN (in tracker_err_calc): start/stop hysteresis.
// Pipeline: input register -> sequencer decision -> output register.
module multi_axis_tracker
    import tracker_pkg::*;
#(
    parameter int N_AXES      = 2,
    parameter int W           = 16,
    parameter int DEADBAND    = 5,
    parameter int HALF_TURN   = 180,
    parameter int DEAD_CYC    = 4,
    parameter int TIMEOUT_CYC = 1000000,
    localparam int AW         = (N_AXES > 1) ? $clog2(N_AXES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  manual,
    input  logic [N_AXES*W-1:0]   sense_a,
    input  logic [N_AXES*W-1:0]   sense_b,
    input  logic [N_AXES*W-1:0]   target,
    input  logic [N_AXES*W-1:0]   actual,
    input  logic [N_AXES-1:0]     wrap_en,
    output logic [N_AXES-1:0]     mot_pos,
    output logic [N_AXES-1:0]     mot_neg,
    output logic [AW-1:0]         active_axis,
    output logic                  busy,
    output logic [N_AXES-1:0]     fault,
    output state_e                dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYC - 1);
    localparam logic [AW-1:0] AXIS_LAST = AW'(N_AXES - 1);

    logic                manual_q, manual_prev_q;
    logic [N_AXES*W-1:0] sense_a_q, sense_b_q, target_q, actual_q;
    logic [N_AXES-1:0]   wrap_q;

    state_e              state_q, state_d;
    brake_ret_e          ret_q, ret_d;
    dir_e                dir_q, dir_d;
    logic [AW-1:0]       axis_q, axis_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [DW-1:0]       dead_q, dead_d;
    logic [N_AXES-1:0]   fault_q, fault_d;
    logic [N_AXES-1:0]   mot_pos_q, mot_pos_d, mot_neg_q, mot_neg_d;
    logic                busy_q, busy_d;
    logic [1:0]          drive_code;

    logic [W-1:0]        sel_sense_a, sel_sense_b, sel_target, sel_actual;
    logic                sel_wrap, aligned, start, mode_chg;
    dir_e                dir;

    // Register every data input once before it reaches the decision logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            manual_q      <= 1'b0;
            manual_prev_q <= 1'b0;
            sense_a_q     <= '0;
            sense_b_q     <= '0;
            target_q      <= '0;
            actual_q      <= '0;
            wrap_q        <= '0;
        end else begin
            manual_q      <= manual;
            manual_prev_q <= manual_q;
            sense_a_q     <= sense_a;
            sense_b_q     <= sense_b;
            target_q      <= target;
            actual_q      <= actual;
            wrap_q        <= wrap_en;
        end
    end

    // Select the words of the currently active axis.
    always_comb begin
        sel_sense_a = sense_a_q[axis_q*W +: W];
        sel_sense_b = sense_b_q[axis_q*W +: W];
        sel_target  = target_q[axis_q*W +: W];
        sel_actual  = actual_q[axis_q*W +: W];
        sel_wrap    = wrap_q[axis_q];
    end

    assign mode_chg = (manual_q != manual_prev_q);

    tracker_err_calc #(
        .W         (W),
        .DEADBAND  (DEADBAND),
        .HALF_TURN (HALF_TURN)
    ) u_err_calc (
        .manual  (manual_q),
        .sense_a (sel_sense_a),
        .sense_b (sel_sense_b),
        .target  (sel_target),
        .actual  (sel_actual),
        .wrap_en (sel_wrap),
        .aligned (aligned),
        .start   (start),
        .dir     (dir)
    );

    // Sequencer next-state: evaluate, drive, brake, advance.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        dir_d   = dir_q;
        axis_d  = axis_q;
        tmo_d   = tmo_q;
        dead_d  = dead_q;
        fault_d = mode_chg ? '0 : fault_q;
        case (state_q)
            ST_EVAL: begin
                if (!start || fault_q[axis_q]) begin
                    state_d = ST_NEXT;
                end else begin
                    dir_d   = dir;
                    tmo_d   = '0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                state_d = ST_BRAKE;
                dead_d  = '0;
                // Aligned is checked before the timeout so it wins a tie.
                if (mode_chg) begin
                    ret_d = RET_RESTART;
                end else if (aligned) begin
                    ret_d = RET_NEXT;
                end else if (dir != dir_q) begin
                    ret_d = RET_EVAL;
                end else if (tmo_q == TMO_LAST) begin
                    ret_d           = RET_NEXT;
                    fault_d[axis_q] = 1'b1;
                end else begin
                    state_d = ST_DRIVE;
                    tmo_d   = tmo_q + 1'b1;
                end
            end
            ST_BRAKE: begin
                if (dead_q == DEAD_LAST) begin
                    dead_d = '0;
                    case (ret_q)
                        RET_NEXT: state_d = ST_NEXT;
                        RET_EVAL: state_d = ST_EVAL;
                        default: begin
                            state_d = ST_EVAL;
                            axis_d  = '0;
                        end
                    endcase
                end else begin
                    dead_d = dead_q + 1'b1;
                end
            end
            ST_NEXT: begin
                axis_d  = (axis_q == AXIS_LAST) ? '0 : axis_q + 1'b1;
                state_d = ST_EVAL;
            end
            default: state_d = ST_EVAL;
        endcase
    end

    // Output stage: only the selected axis is ever driven, and only in DRIVE.
    always_comb begin
        mot_pos_d  = '1;
        mot_neg_d  = '1;
        drive_code = dir_to_mot(dir_q);
        busy_d     = (state_q == ST_DRIVE) || (state_q == ST_BRAKE);
        if (state_q == ST_DRIVE) begin
            {mot_pos_d[axis_q], mot_neg_d[axis_q]} = drive_code;
        end
    end

    // Sequencer state and output registers; reset forces the motors to stop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_EVAL;
            ret_q     <= RET_NEXT;
            dir_q     <= DIR_UP;
            axis_q    <= '0;
            tmo_q     <= '0;
            dead_q    <= '0;
            fault_q   <= '0;
            mot_pos_q <= '1;
            mot_neg_q <= '1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            dir_q     <= dir_d;
            axis_q    <= axis_d;
            tmo_q     <= tmo_d;
            dead_q    <= dead_d;
            fault_q   <= fault_d;
            mot_pos_q <= mot_pos_d;
            mot_neg_q <= mot_neg_d;
            busy_q    <= busy_d;
        end
    end

    assign mot_pos     = mot_pos_q;
    assign mot_neg     = mot_neg_q;
    assign active_axis = axis_q;
    assign busy        = busy_q;
    assign fault       = fault_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_multi_axis_tracker.sv
// Bench for multi_axis_tracker (2 axes, 16-bit words, TIMEOUT_CYC = 50).
// Expected drive codes come from a plain-arithmetic model of the tracking rules.
module tb_multi_axis_tracker;
    import tracker_pkg::*;

    localparam int N    = 2;
    localparam int W    = 16;
    localparam int DB   = 5;
    localparam int HALF = 180;
    localparam int DEAD = 4;
    localparam int TMO  = 50;
`ifdef TRACKER_HYST_EN
    localparam int START_THR = 2 * DB;
`else
    localparam int START_THR = DB;
`endif

    logic           clk;
    logic           rst;
    logic           manual;
    logic [N*W-1:0] sense_a, sense_b, target, actual;
    logic [N-1:0]   wrap_en, mot_pos, mot_neg, fault;
    logic [0:0]     active_axis;
    logic           busy;
    state_e         dbg_state;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int bad00   = 0;
    int multi   = 0;

    multi_axis_tracker #(
        .N_AXES      (N),
        .W           (W),
        .DEADBAND    (DB),
        .HALF_TURN   (HALF),
        .DEAD_CYC    (DEAD),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .manual      (manual),
        .sense_a     (sense_a),
        .sense_b     (sense_b),
        .target      (target),
        .actual      (actual),
        .wrap_en     (wrap_en),
        .mot_pos     (mot_pos),
        .mot_neg     (mot_neg),
        .active_axis (active_axis),
        .busy        (busy),
        .fault       (fault),
        .dbg_state   (dbg_state)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    // Background monitor: 00 must never appear, at most one axis driven.
    always @(negedge clk) begin : mon
        int drv;
        drv = 0;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                if (!mot_pos[i] && !mot_neg[i]) bad00++;
                if (!(mot_pos[i] && mot_neg[i])) drv++;
            end
            if (drv > 1) multi++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: drive code the axis should start with, from its error.
    function automatic logic [1:0] model_code(input bit man, input int a, input int b, input bit wrap);
        int err;
        int mag;
        bit up;
        err = b - a;
        mag = (err < 0) ? -err : err;
        if (mag <= START_THR) return 2'b11;
        up = (err > 0);
        if (man && wrap && mag > HALF) up = !up;
        return up ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] code_of(input int ax);
        return {mot_pos[ax], mot_neg[ax]};
    endfunction

    function automatic bit all_stop();
        return (mot_pos == '1) && (mot_neg == '1);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_inputs();
        sense_a = '0;
        sense_b = '0;
        target  = '0;
        actual  = '0;
        wrap_en = '0;
    endtask

    // Error for the axis is b - a in either mode (sense_b - sense_a, target - actual).
    task automatic set_axis(input int ax, input int a, input int b, input bit wrap);
        clear_inputs();
        sense_a[ax*W +: W] = W'(a);
        sense_b[ax*W +: W] = W'(b);
        actual[ax*W +: W]  = W'(a);
        target[ax*W +: W]  = W'(b);
        wrap_en[ax]        = wrap;
    endtask

    task automatic first_code(input int ax, input int budget, output logic [1:0] c);
        c = 2'b11;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (code_of(ax) != 2'b11) begin
                c = code_of(ax);
                break;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int quiet;
        quiet = 0;
        for (int k = 0; k < 60; k++) begin
            cyc(1);
            if (!busy && all_stop()) quiet++;
            else quiet = 0;
            if (quiet >= 3) break;
        end
        chk({tag, "_idle"}, 32'(quiet >= 3), 1);
    endtask

    // Waits for the motors to stop, then counts braking cycles (busy, all 11).
    task automatic brake_len(output int n);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            if (all_stop()) break;
            cyc(1);
        end
        while (n < 20 && busy && all_stop()) begin
            n++;
            cyc(1);
        end
    endtask

    task automatic start_case(input string tag, input int ax, input bit man,
                              input int a, input int b, input bit wrap);
        logic [1:0] got;
        logic [1:0] exp;
        exp = model_code(man, a, b, wrap);
        set_axis(ax, a, b, wrap);
        first_code(ax, 24, got);
        chk(tag, got, exp);
        clear_inputs();
        wait_idle(tag);
    endtask

    initial begin
        logic [1:0] c;
        int n;
        int a;
        int b;
        int ax;
        int changes;
        int seen_busy;
        int seen_drive;
        int found;
        logic [0:0] prev;

        // Reset state.
        rst    = 1'b1;
        manual = 1'b0;
        clear_inputs();
        #1 rst = 1'b0;
        cyc(3);
        chk("rst_mot_pos", mot_pos, 2'b11);
        chk("rst_mot_neg", mot_neg, 2'b11);
        chk("rst_axis", active_axis, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        chk("rst_state", dbg_state, ST_EVAL);
        rst = 1'b1;

        // All aligned: axis advances every 2 cycles, nothing moves.
        cyc(2);
        prev = active_axis;
        changes = 0;
        seen_busy = 0;
        seen_drive = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            if (active_axis != prev) changes++;
            prev = active_axis;
            if (busy) seen_busy++;
            if (!all_stop()) seen_drive++;
        end
        chk("idle_axis_steps", changes, 4);
        chk("idle_busy", seen_busy, 0);
        chk("idle_motors", seen_drive, 0);

        // Auto drive with 3-cycle latency: present inputs just before axis 0 is evaluated.
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (dbg_state == ST_NEXT && active_axis == 1'b1) begin
                found = 1;
                break;
            end
            cyc(1);
        end
        chk("sync_axis1_next", found, 1);
        set_axis(0, 100, 200, 1'b0);
        cyc(2);
        chk("lat_before3", code_of(0), 2'b11);
        cyc(1);
        chk("lat3_drive", code_of(0), model_code(1'b0, 100, 200, 1'b0));
        cyc(4);
        chk("drive_busy", busy, 1);
        chk("drive_hold", code_of(0), 2'b10);
        set_axis(0, 197, 200, 1'b0);
        brake_len(n);
        chk("stop_brake_len", n, DEAD);
        found = 0;
        for (int k = 0; k < 6; k++) begin
            if (active_axis == 1'b1) begin
                found = 1;
                break;
            end
            cyc(1);
        end
        chk("stop_next_axis", found, 1);
        clear_inputs();
        wait_idle("stop");

        // Underflow guard and deadband edges in auto mode.
        start_case("underflow", 0, 1'b0, 2, 0, 1'b0);
        start_case("db_pos_edge", 1, 1'b0, 0, DB, 1'b0);
        start_case("db_neg_edge", 0, 1'b0, DB, 0, 1'b0);
        start_case("db_plus1", 1, 1'b0, 0, DB + 1, 1'b0);
        start_case("auto_wide", 0, 1'b0, 65535, 0, 1'b1);

        // Randomized auto cases; wrap_en must be ignored in auto mode.
        for (int it = 0; it < 8; it++) begin
            ax = int'($urandom_range(0, N - 1));
            a  = int'($urandom_range(0, 65535));
            if (it % 2 == 1) begin
                b = a + int'($urandom_range(0, 24)) - 12;
                if (b < 0) b = 0;
                if (b > 65535) b = 65535;
            end else begin
                b = int'($urandom_range(0, 65535));
            end
            start_case("auto_rand", ax, 1'b0, a, b, 1'($urandom_range(0, 1)));
        end

        // Manual mode with circular axes.
        manual = 1'b1;
        cyc(3);
        start_case("wrap_inv", 1, 1'b1, 350, 10, 1'b1);
        start_case("wrap_off", 1, 1'b1, 350, 10, 1'b0);
        start_case("half_turn_eq", 0, 1'b1, 0, HALF, 1'b1);
        start_case("half_turn_over", 0, 1'b1, 0, HALF + 1, 1'b1);
        start_case("hyst_err8", 0, 1'b1, 0, 8, 1'b0);
        start_case("hyst_err11", 1, 1'b1, 20, 9, 1'b0);
        for (int it = 0; it < 8; it++) begin
            ax = int'($urandom_range(0, N - 1));
            a  = int'($urandom_range(0, 359));
            b  = int'($urandom_range(0, 359));
            start_case("manual_rand", ax, 1'b1, a, b, 1'($urandom_range(0, 1)));
        end

        // Reversal: dead-time, then the opposite direction on the same axis.
        set_axis(0, 0, 100, 1'b0);
        first_code(0, 24, c);
        chk("rev_first", c, 2'b10);
        set_axis(0, 200, 100, 1'b0);
        brake_len(n);
        chk("rev_brake_len", n, DEAD);
        first_code(0, 12, c);
        chk("rev_second", c, 2'b01);
        chk("rev_same_axis", active_axis, 0);
        chk("rev_no_fault", fault, 0);
        clear_inputs();
        wait_idle("rev");

        // Timeout: axis 0 never reaches its target.
        set_axis(0, 0, 1000, 1'b0);
        first_code(0, 24, c);
        chk("tmo_dir", c, 2'b10);
        n = (c != 2'b11) ? 1 : 0;
        for (int k = 0; k < 200; k++) begin
            cyc(1);
            if (code_of(0) == 2'b11) break;
            n++;
        end
        chk("tmo_drive_len", n, TMO);
        chk("tmo_fault", fault, 2'b01);
        seen_drive = 0;
        for (int k = 0; k < 30; k++) begin
            cyc(1);
            if (code_of(0) != 2'b11) seen_drive++;
        end
        chk("tmo_skip", seen_drive, 0);
        chk("tmo_sticky", fault, 2'b01);
        clear_inputs();
        manual = 1'b0;
        cyc(3);
        chk("tmo_mode_clear", fault, 0);

        // Asynchronous reset in the middle of a drive.
        set_axis(1, 0, 1000, 1'b0);
        first_code(1, 24, c);
        chk("ar_drive", c, 2'b10);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("ar_mot_pos", mot_pos, 2'b11);
        chk("ar_mot_neg", mot_neg, 2'b11);
        chk("ar_busy", busy, 0);
        chk("ar_axis", active_axis, 0);
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        wait_idle("ar");

        chk("never_00", bad00, 0);
        chk("one_axis_at_a_time", multi, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
